mem_arbiter: RTL and testbench

- Shares the single unified memory port between the fetch stage (instruction reads) and the MEM stage (data reads/writes with byte enables).
- Sits between the pipeline stages and the memory module. Produces the per-requester ready strobes (imem_r / dmem_r) that feed the fetch and MEM stall logic.
- Data requests win by default, since the MEM-stage instruction is the older one. A bounded-wait counter prevents fetch starvation.
- Supports cancelling an in-flight fetch on a branch/trap redirect.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_wait_counter.sv | 22 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and defaults for the memory port arbiter
`ifndef MEM_ARBITER_PKG_SV
`define MEM_ARBITER_PKG_SV
package mem_arbiter_pkg;
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_IF_BUSY = 2'd1;
    localparam logic [1:0] ARB_D_BUSY  = 2'd2;
    localparam logic [1:0] ARB_IF_DROP = 2'd3;
    localparam int IF_MAX_WAIT_DEF = 4;
    typedef enum logic [1:0] {
        S_IDLE    = ARB_IDLE,
        S_IF_BUSY = ARB_IF_BUSY,
        S_D_BUSY  = ARB_D_BUSY,
        S_IF_DROP = ARB_IF_DROP
    } arb_state_e;
endpackage
`endif

// File: rtl/mem_arbiter_wait_counter.sv
// arb_wait_counter: counts data grants a pending fetch has lost and flags when fetch must win
module arb_wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int IF_MAX_WAIT = IF_MAX_WAIT_DEF,
    parameter int WAIT_W      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_force_if
);
    logic [WAIT_W-1:0] r_cnt;
    // saturating counter; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + WAIT_W'(1);
    end
    assign o_force_if = r_cnt >= WAIT_W'(IF_MAX_WAIT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch reads and MEM-stage data accesses
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int IF_MAX_WAIT = IF_MAX_WAIT_DEF,
    parameter int WAIT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    input  logic        i_if_flush,
    output logic [15:0] o_if_rdata,
    output logic        o_if_r,
    input  logic        i_d_req,
    input  logic [15:0] i_d_addr,
    input  logic        i_d_we_low,
    input  logic        i_d_we_high,
    input  logic [15:0] i_d_wdata,
    output logic [15:0] o_d_rdata,
    output logic        o_d_r,
    output logic [15:0] o_ram_addr,
    output logic        o_ram_en,
    output logic        o_ram_we_low,
    output logic        o_ram_we_high,
    output logic [15:0] o_ram_wdata,
    input  logic [15:0] i_ram_rdata,
    input  logic        i_ram_r
);
    arb_state_e  r_state, w_state;
    logic [15:0] r_if_rdata, w_if_rdata, r_d_rdata, w_d_rdata;
    logic [15:0] r_ram_addr, w_ram_addr, r_ram_wdata, w_ram_wdata;
    logic        r_if_r, w_if_r, r_d_r, w_d_r;
    logic        r_ram_en, w_ram_en, r_we_lo, w_we_lo, r_we_hi, w_we_hi;
    logic        w_idle, w_if_live, w_d_live, w_grant_d, w_grant_if, w_force_if, w_inc, w_clr;

    // a requester still showing its strobe has a stale req and is not eligible
    assign w_idle     = r_state == S_IDLE;
    assign w_if_live  = i_if_req & ~i_if_flush & ~r_if_r;
    assign w_d_live   = i_d_req & ~r_d_r;
    assign w_grant_d  = w_idle & w_d_live & ~(w_if_live & w_force_if);
    assign w_grant_if = w_idle & w_if_live & ~w_grant_d;
    assign w_inc      = w_idle & w_d_live & w_if_live & ~w_force_if;
    assign w_clr      = w_grant_if | ~i_if_req | i_if_flush;

    arb_wait_counter #(.IF_MAX_WAIT(IF_MAX_WAIT), .WAIT_W(WAIT_W)) u_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_inc      (w_inc),
        .o_force_if (w_force_if)
    );

    // next state and next registered outputs; strobes default low, everything else holds
    always_comb begin
        w_state     = r_state;
        w_if_r      = 1'b0;
        w_d_r       = 1'b0;
        w_if_rdata  = r_if_rdata;
        w_d_rdata   = r_d_rdata;
        w_ram_addr  = r_ram_addr;
        w_ram_en    = r_ram_en;
        w_we_lo     = r_we_lo;
        w_we_hi     = r_we_hi;
        w_ram_wdata = r_ram_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_ram_addr  = i_d_addr;
                    w_ram_en    = 1'b1;
                    w_we_lo     = i_d_we_low;
                    w_we_hi     = i_d_we_high;
                    w_ram_wdata = i_d_wdata;
                    w_state     = S_D_BUSY;
                end else if (w_grant_if) begin
                    w_ram_addr = i_if_addr;
                    w_ram_en   = 1'b1;
                    w_we_lo    = 1'b0;
                    w_we_hi    = 1'b0;
                    w_state    = S_IF_BUSY;
                end
            end
            S_IF_BUSY: begin
                if (i_ram_r) begin
                    w_ram_en   = 1'b0;
                    w_state    = S_IDLE;
                    w_if_r     = ~i_if_flush;
                    w_if_rdata = i_if_flush ? r_if_rdata : i_ram_rdata;
                end else if (i_if_flush) begin
                    w_state = S_IF_DROP;
                end
            end
            S_IF_DROP: begin
                if (i_ram_r) begin
                    w_ram_en = 1'b0;
                    w_state  = S_IDLE;
                end
            end
            S_D_BUSY: begin
                if (i_ram_r) begin
                    w_ram_en  = 1'b0;
                    w_we_lo   = 1'b0;
                    w_we_hi   = 1'b0;
                    w_d_r     = 1'b1;
                    w_d_rdata = i_ram_rdata;
                    w_state   = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // state and all outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_if_r      <= 1'b0;
            r_d_r       <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_ram_addr  <= '0;
            r_ram_en    <= 1'b0;
            r_we_lo     <= 1'b0;
            r_we_hi     <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_state     <= w_state;
            r_if_r      <= w_if_r;
            r_d_r       <= w_d_r;
            r_if_rdata  <= w_if_rdata;
            r_d_rdata   <= w_d_rdata;
            r_ram_addr  <= w_ram_addr;
            r_ram_en    <= w_ram_en;
            r_we_lo     <= w_we_lo;
            r_we_hi     <= w_we_hi;
            r_ram_wdata <= w_ram_wdata;
        end
    end

    assign o_if_rdata    = r_if_rdata;
    assign o_if_r        = r_if_r;
    assign o_d_rdata     = r_d_rdata;
    assign o_d_r         = r_d_r;
    assign o_ram_addr    = r_ram_addr;
    assign o_ram_en      = r_ram_en;
    assign o_ram_we_low  = r_we_lo;
    assign o_ram_we_high = r_we_hi;
    assign o_ram_wdata   = r_ram_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard-driven scenario bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, if_r;
    logic [15:0] if_addr = '0, if_rdata;
    logic        d_req = 1'b0, d_we_low = 1'b0, d_we_high = 1'b0, d_r;
    logic [15:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic [15:0] ram_addr, ram_wdata, ram_rdata = '0;
    logic        ram_en, ram_we_low, ram_we_high, ram_r = 1'b0;

    typedef struct {logic [15:0] addr; logic wl; logic wh; logic [15:0] wdata;} acc_t;
    typedef struct {logic is_if; logic [15:0] data;} st_t;
    acc_t acc_q[$];
    st_t  st_q[$];
    int vectors = 0, miscompares = 0;
    logic [15:0] last_if_rdata = '0;

    mem_arbiter #(.IF_MAX_WAIT(4), .WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_rdata(if_rdata), .o_if_r(if_r),
        .i_d_req(d_req), .i_d_addr(d_addr), .i_d_we_low(d_we_low), .i_d_we_high(d_we_high),
        .i_d_wdata(d_wdata), .o_d_rdata(d_rdata), .o_d_r(d_r),
        .o_ram_addr(ram_addr), .o_ram_en(ram_en), .o_ram_we_low(ram_we_low),
        .o_ram_we_high(ram_we_high), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .i_ram_r(ram_r)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end (got timeout, expected finish)");
        $fatal(1);
    end

    function automatic acc_t mk_acc(input logic [15:0] a, input logic wl, input logic wh, input logic [15:0] wd);
        acc_t e;
        e.addr = a; e.wl = wl; e.wh = wh; e.wdata = wd;
        return e;
    endfunction

    function automatic st_t mk_st(input logic is_if, input logic [15:0] d);
        st_t s;
        s.is_if = is_if; s.data = d;
        return s;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            n++;
            ok = ram_en;
        end
    endtask

    task automatic test_reset;
        step();
        vectors++;
        if ({if_r, d_r, if_rdata, d_rdata, ram_en, ram_we_low, ram_we_high, ram_addr, ram_wdata} !== '0)
            begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", {if_r, d_r, if_rdata, d_rdata, ram_en, ram_we_low, ram_we_high, ram_addr, ram_wdata}); end
        vectors++;
        if (dut.r_state !== ARB_IDLE || dut.u_wait.r_cnt !== 4'd0)
            begin miscompares++; $display("FAIL reset_state: got state %0d cnt %0d expected 0 0", dut.r_state, dut.u_wait.r_cnt); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fetch_only;
        int n; bit ok; acc_t e; st_t s;
        acc_q.push_back(mk_acc(16'h3000, 1'b0, 1'b0, 16'h0));
        if_addr = 16'h3000; if_req = 1'b1;
        wait_en(n, ok);
        vectors++;
        if (!ok || n != 1) begin miscompares++; $display("FAIL fetch_grant_latency: got ok=%0d n=%0d expected 1 1", ok, n); end
        e = acc_q.pop_front();
        vectors++;
        if ({ram_addr, ram_we_low, ram_we_high} !== {e.addr, e.wl, e.wh})
            begin miscompares++; $display("FAIL fetch_access: got %h/%b%b expected %h/%b%b", ram_addr, ram_we_low, ram_we_high, e.addr, e.wl, e.wh); end
        ram_r = 1'b1; ram_rdata = 16'h1234;
        st_q.push_back(mk_st(1'b1, 16'h1234));
        step();
        s = st_q.pop_front();
        vectors++;
        if ({if_r, d_r, if_rdata} !== {s.is_if, ~s.is_if, s.data})
            begin miscompares++; $display("FAIL fetch_strobe: got if_r=%b d_r=%b data=%h expected %b %b %h", if_r, d_r, if_rdata, s.is_if, ~s.is_if, s.data); end
        last_if_rdata = 16'h1234;
        vectors++;
        if (ram_en !== 1'b0) begin miscompares++; $display("FAIL fetch_en_drop: got %b expected 0", ram_en); end
        ram_r = 1'b0; if_req = 1'b0;
        step();
        vectors++;
        if (if_r !== 1'b0) begin miscompares++; $display("FAIL fetch_strobe_width: got %b expected 0", if_r); end
    endtask

    task automatic test_simultaneous;
        int n; bit ok; acc_t e; st_t s;
        acc_q.push_back(mk_acc(16'h4000, 1'b0, 1'b1, 16'hABCD));
        acc_q.push_back(mk_acc(16'h3002, 1'b0, 1'b0, 16'h0));
        if_addr = 16'h3002; d_addr = 16'h4000; d_we_high = 1'b1; d_wdata = 16'hABCD;
        if_req = 1'b1; d_req = 1'b1;
        wait_en(n, ok);
        e = acc_q.pop_front();
        vectors++;
        if (!ok || {ram_addr, ram_we_low, ram_we_high, ram_wdata} !== {e.addr, e.wl, e.wh, e.wdata})
            begin miscompares++; $display("FAIL sim_data_first: got %h/%b%b/%h expected %h/%b%b/%h", ram_addr, ram_we_low, ram_we_high, ram_wdata, e.addr, e.wl, e.wh, e.wdata); end
        vectors++;
        if (dut.u_wait.r_cnt !== 4'd1) begin miscompares++; $display("FAIL sim_wait_inc: got %0d expected 1", dut.u_wait.r_cnt); end
        ram_r = 1'b1; ram_rdata = 16'h5555;
        st_q.push_back(mk_st(1'b0, 16'h5555));
        step();
        s = st_q.pop_front();
        vectors++;
        if ({if_r, d_r, d_rdata} !== {s.is_if, ~s.is_if, s.data})
            begin miscompares++; $display("FAIL sim_d_strobe: got if_r=%b d_r=%b data=%h expected %b %b %h", if_r, d_r, d_rdata, s.is_if, ~s.is_if, s.data); end
        d_req = 1'b0; d_we_high = 1'b0; ram_r = 1'b0;
        wait_en(n, ok);
        e = acc_q.pop_front();
        vectors++;
        if (!ok || n != 1 || {ram_addr, ram_we_low, ram_we_high} !== {e.addr, e.wl, e.wh})
            begin miscompares++; $display("FAIL sim_if_next: got n=%0d %h/%b%b expected 1 %h/%b%b", n, ram_addr, ram_we_low, ram_we_high, e.addr, e.wl, e.wh); end
        vectors++;
        if (dut.u_wait.r_cnt !== 4'd0) begin miscompares++; $display("FAIL sim_wait_clr: got %0d expected 0", dut.u_wait.r_cnt); end
        ram_r = 1'b1; ram_rdata = 16'h7777;
        st_q.push_back(mk_st(1'b1, 16'h7777));
        step();
        s = st_q.pop_front();
        vectors++;
        if ({if_r, d_r, if_rdata} !== {s.is_if, ~s.is_if, s.data})
            begin miscompares++; $display("FAIL sim_if_strobe: got if_r=%b d_r=%b data=%h expected %b %b %h", if_r, d_r, if_rdata, s.is_if, ~s.is_if, s.data); end
        last_if_rdata = 16'h7777;
        if_req = 1'b0; ram_r = 1'b0;
        step();
    endtask

    task automatic test_starvation_bound;
        acc_t e;
        bit prev_en = 1'b0;
        int d_run = 0, max_run = 0;
        for (int k = 0; k < 3; k++) begin
            acc_q.push_back(mk_acc(16'h4100, 1'b0, 1'b0, 16'h0));
            acc_q.push_back(mk_acc(16'h3100, 1'b0, 1'b0, 16'h0));
        end
        d_addr = 16'h4100; if_addr = 16'h3100; ram_rdata = 16'h2222; ram_r = 1'b1;
        d_req = 1'b1; if_req = 1'b1;
        for (int c = 0; c < 40 && acc_q.size() != 0; c++) begin
            step();
            if (ram_en && !prev_en) begin
                e = acc_q.pop_front();
                vectors++;
                if (ram_addr !== e.addr) begin miscompares++; $display("FAIL starve_order: got %h expected %h", ram_addr, e.addr); end
                d_run = (ram_addr == 16'h4100) ? d_run + 1 : 0;
                max_run = d_run > max_run ? d_run : max_run;
            end
            prev_en = ram_en;
        end
        vectors++;
        if (acc_q.size() != 0) begin miscompares++; $display("FAIL starve_timeout: got %0d pending expected 0", acc_q.size()); acc_q.delete(); end
        vectors++;
        if (max_run > 4) begin miscompares++; $display("FAIL starve_bound: got %0d consecutive data grants expected <= 4", max_run); end
        vectors++;
        if (dut.u_wait.r_cnt !== 4'd0) begin miscompares++; $display("FAIL starve_wait_clr: got %0d expected 0", dut.u_wait.r_cnt); end
        d_req = 1'b0; if_req = 1'b0;
        step();
        last_if_rdata = 16'h2222;
        ram_r = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        int t0 = -1, t1 = -1, strobes = 0;
        bit prev_en = 1'b0;
        d_addr = 16'h4200; d_we_low = 1'b1; d_wdata = 16'h0F0F; ram_r = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 20 && t1 < 0; c++) begin
            step();
            if (d_r) strobes++;
            if (ram_en && !prev_en) begin
                if (t0 < 0) t0 = c; else t1 = c;
                vectors++;
                if ({ram_addr, ram_we_low, ram_we_high} !== {16'h4200, 1'b1, 1'b0})
                    begin miscompares++; $display("FAIL b2b_access: got %h/%b%b expected 4200/10", ram_addr, ram_we_low, ram_we_high); end
            end
            prev_en = ram_en;
        end
        vectors++;
        if (t1 - t0 != 3 || strobes != 1) begin miscompares++; $display("FAIL b2b_period: got %0d cycles %0d strobes expected 3 1", t1 - t0, strobes); end
        d_req = 1'b0; d_we_low = 1'b0;
        step();
        ram_r = 1'b0;
        step();
    endtask

    task automatic test_flush_inflight;
        int n; bit ok; acc_t e;
        acc_q.push_back(mk_acc(16'h3200, 1'b0, 1'b0, 16'h0));
        if_addr = 16'h3200; if_req = 1'b1;
        wait_en(n, ok);
        e = acc_q.pop_front();
        vectors++;
        if (!ok || ram_addr !== e.addr) begin miscompares++; $display("FAIL flush_grant: got %h expected %h", ram_addr, e.addr); end
        if_flush = 1'b1;
        step();
        vectors++;
        if (dut.r_state !== ARB_IF_DROP || ram_en !== 1'b1)
            begin miscompares++; $display("FAIL flush_drop: got state %0d en %b expected 3 1", dut.r_state, ram_en); end
        if_flush = 1'b0; if_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if (dut.r_state !== ARB_IF_DROP || ram_en !== 1'b1 || if_r !== 1'b0)
                begin miscompares++; $display("FAIL flush_hold: got state %0d en %b if_r %b expected 3 1 0", dut.r_state, ram_en, if_r); end
        end
        ram_r = 1'b1; ram_rdata = 16'hDEAD;
        step();
        vectors++;
        if (dut.r_state !== ARB_IDLE || ram_en !== 1'b0 || if_r !== 1'b0)
            begin miscompares++; $display("FAIL flush_done: got state %0d en %b if_r %b expected 0 0 0", dut.r_state, ram_en, if_r); end
        ram_r = 1'b0;
        step();
        vectors++;
        if (if_r !== 1'b0 || if_rdata !== last_if_rdata)
            begin miscompares++; $display("FAIL flush_data: got if_r %b data %h expected 0 %h", if_r, if_rdata, last_if_rdata); end
    endtask

    task automatic test_flush_coincident;
        int n; bit ok; acc_t e; st_t s;
        if_addr = 16'h3300; if_req = 1'b1;
        wait_en(n, ok);
        vectors++;
        if (!ok || ram_addr !== 16'h3300) begin miscompares++; $display("FAIL coinc_grant: got %h expected 3300", ram_addr); end
        if_flush = 1'b1; ram_r = 1'b1; ram_rdata = 16'hBEEF;
        d_addr = 16'h4300; d_we_low = 1'b1; d_we_high = 1'b0; d_wdata = 16'h1111; d_req = 1'b1;
        acc_q.push_back(mk_acc(16'h4300, 1'b1, 1'b0, 16'h1111));
        step();
        vectors++;
        if (if_r !== 1'b0 || if_rdata !== last_if_rdata || dut.r_state !== ARB_IDLE || ram_en !== 1'b0)
            begin miscompares++; $display("FAIL coinc_discard: got if_r %b data %h state %0d en %b expected 0 %h 0 0", if_r, if_rdata, dut.r_state, ram_en, last_if_rdata); end
        if_flush = 1'b0; if_req = 1'b0; ram_r = 1'b0;
        wait_en(n, ok);
        e = acc_q.pop_front();
        vectors++;
        if (!ok || n != 1 || {ram_addr, ram_we_low, ram_we_high, ram_wdata} !== {e.addr, e.wl, e.wh, e.wdata})
            begin miscompares++; $display("FAIL coinc_d_grant: got n=%0d %h/%b%b/%h expected 1 %h/%b%b/%h", n, ram_addr, ram_we_low, ram_we_high, ram_wdata, e.addr, e.wl, e.wh, e.wdata); end
        ram_r = 1'b1; ram_rdata = 16'h2468;
        st_q.push_back(mk_st(1'b0, 16'h2468));
        step();
        s = st_q.pop_front();
        vectors++;
        if ({if_r, d_r, d_rdata, ram_we_low} !== {s.is_if, ~s.is_if, s.data, 1'b0})
            begin miscompares++; $display("FAIL coinc_d_strobe: got if_r %b d_r %b data %h we %b expected %b %b %h 0", if_r, d_r, d_rdata, ram_we_low, s.is_if, ~s.is_if, s.data); end
        d_req = 1'b0; d_we_low = 1'b0; ram_r = 1'b0;
        step();
    endtask

    task automatic test_reset_mid;
        int n; bit ok;
        d_addr = 16'h4400; d_we_low = 1'b1; d_wdata = 16'h5A5A; d_req = 1'b1;
        wait_en(n, ok);
        vectors++;
        if (!ok || ram_we_low !== 1'b1 || dut.r_state !== ARB_D_BUSY)
            begin miscompares++; $display("FAIL rstmid_busy: got we %b state %0d expected 1 2", ram_we_low, dut.r_state); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ram_en, ram_we_low, ram_we_high, d_r} !== 4'b0 || dut.r_state !== ARB_IDLE)
            begin miscompares++; $display("FAIL rstmid_async: got %b state %0d expected 0000 0", {ram_en, ram_we_low, ram_we_high, d_r}, dut.r_state); end
        d_req = 1'b0; d_we_low = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if ({ram_en, ram_we_low, d_r} !== 3'b0)
                begin miscompares++; $display("FAIL rstmid_after: got %b expected 000", {ram_en, ram_we_low, d_r}); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation_bound();
        test_back_to_back();
        test_flush_inflight();
        test_flush_coincident();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
